vending_machine_param: RTL and testbench

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vending_machine_param.sv | 171 +++++++++++++++++
 tb/tb_vending_machine_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parameterised vending machine.
// The machine accumulates nickel/dime/quarter credit toward PRICE_UNITS, vends
// with change, or refunds on cancel. Each outcome is held until the dispenser
// acknowledges it. Every output is registered. The state is exposed on
// o_dbg_state for observation.
//
// Handshake: entering VEND or REFUND raises o_busy together with o_soda and
// o_change. These outputs stay stable until i_ack is sampled high at a rising
// edge. On that same edge the machine returns to IDLE, and o_soda, o_change
// and o_busy drop. i_ack has no effect at any other time.
module vending_machine_param #(
  parameter int PRICE_UNITS = 5,
  parameter int CREDIT_W    = 4,
  parameter int COUNT_W     = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_nickle,
  input  logic                i_dime,
  input  logic                i_quarter,
  input  logic                i_cancel,
  input  logic                i_ack,
  output logic                o_soda,
  output logic [CREDIT_W-1:0] o_change,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_reject,
  output logic                o_busy,
  output logic [COUNT_W-1:0]  o_sales,
  output logic [1:0]          o_dbg_state
);

  // Credit never exceeds PRICE_UNITS+4, so this width check makes overflow impossible.
  if ((1 << CREDIT_W) <= PRICE_UNITS + 4) begin : g_bad_credit_w
    $error("CREDIT_W too small: 2^CREDIT_W must exceed PRICE_UNITS+4");
  end
  if (PRICE_UNITS < 1 || PRICE_UNITS > 63) begin : g_bad_price
    $error("PRICE_UNITS must lie in 1..63");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_V   = CREDIT_W'(PRICE_UNITS);
  localparam logic [CREDIT_W-1:0] NICKEL_V  = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] DIME_V    = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] QUARTER_V = CREDIT_W'(5);

  state_t               r_state;
  logic                 r_soda;
  logic [CREDIT_W-1:0]  r_change;
  logic [CREDIT_W-1:0]  r_credit;
  logic                 r_reject;
  logic                 r_busy;
  logic [COUNT_W-1:0]   r_sales;

  state_t               w_state_nx;
  logic                 w_soda_nx;
  logic [CREDIT_W-1:0]  w_change_nx;
  logic [CREDIT_W-1:0]  w_credit_nx;
  logic                 w_reject_nx;
  logic                 w_busy_nx;
  logic [COUNT_W-1:0]   w_sales_nx;

  logic [1:0]           w_coin_cnt;
  logic                 w_any_coin;
  logic                 w_one_coin;
  logic                 w_multi_coin;
  logic [CREDIT_W-1:0]  w_coin_val;
  logic [CREDIT_W-1:0]  w_sum;

  // Decode the coin inputs: how many coins are high, and the value of a lone coin.
  always_comb begin
    w_coin_cnt   = {1'b0, i_nickle} + {1'b0, i_dime} + {1'b0, i_quarter};
    w_any_coin   = i_nickle | i_dime | i_quarter;
    w_one_coin   = (w_coin_cnt == 2'd1);
    w_multi_coin = (w_coin_cnt >= 2'd2);
    w_coin_val   = '0;
    if (i_nickle)       w_coin_val = NICKEL_V;
    else if (i_dime)    w_coin_val = DIME_V;
    else if (i_quarter) w_coin_val = QUARTER_V;
    // Simultaneous coins are refused and add nothing to the credit.
    w_sum = r_credit + (w_one_coin ? w_coin_val : '0);
  end

  // Next-state and next-output logic. Outputs hold their value unless changed below.
  always_comb begin
    w_state_nx  = r_state;
    w_soda_nx   = r_soda;
    w_change_nx = r_change;
    w_credit_nx = r_credit;
    w_reject_nx = 1'b0;
    w_busy_nx   = r_busy;
    w_sales_nx  = r_sales;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        w_reject_nx = w_multi_coin;
        // Cancel wins over reaching the price. In IDLE it matters only with a real coin.
        if (i_cancel && (r_state == S_COLLECT || w_one_coin)) begin
          w_state_nx  = S_REFUND;
          w_soda_nx   = 1'b0;
          w_change_nx = w_sum;
          w_credit_nx = '0;
          w_busy_nx   = 1'b1;
        end else if (w_one_coin) begin
          if (w_sum >= PRICE_V) begin
            w_state_nx  = S_VEND;
            w_soda_nx   = 1'b1;
            w_change_nx = w_sum - PRICE_V;
            w_credit_nx = '0;
            w_busy_nx   = 1'b1;
          end else begin
            w_state_nx  = S_COLLECT;
            w_credit_nx = w_sum;
          end
        end
      end
      S_VEND, S_REFUND: begin
        w_reject_nx = w_any_coin;
        if (i_ack) begin
          w_state_nx  = S_IDLE;
          w_soda_nx   = 1'b0;
          w_change_nx = '0;
          w_busy_nx   = 1'b0;
          if (r_state == S_VEND) w_sales_nx = r_sales + COUNT_W'(1);
        end
      end
      default: begin
        w_state_nx  = S_IDLE;
        w_soda_nx   = 1'b0;
        w_change_nx = '0;
        w_credit_nx = '0;
        w_busy_nx   = 1'b0;
        w_sales_nx  = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_soda   <= 1'b0;
      r_change <= '0;
      r_credit <= '0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
      r_sales  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_soda   <= w_soda_nx;
      r_change <= w_change_nx;
      r_credit <= w_credit_nx;
      r_reject <= w_reject_nx;
      r_busy   <= w_busy_nx;
      r_sales  <= w_sales_nx;
    end
  end

  assign o_soda      = r_soda;
  assign o_change    = r_change;
  assign o_credit    = r_credit;
  assign o_reject    = r_reject;
  assign o_busy      = r_busy;
  assign o_sales     = r_sales;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param with the default parameters.
// A transaction-level model (credit total, pending outcome, sale count) is
// checked against every output on every falling edge. Literal expectations
// along the directed sequences pin the model itself.
module tb_vending_machine_param;
  localparam int PRICE_UNITS = 5;
  localparam int CREDIT_W    = 4;
  localparam int COUNT_W     = 8;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic                i_nickle = 1'b0, i_dime = 1'b0, i_quarter = 1'b0;
  logic                i_cancel = 1'b0, i_ack = 1'b0;
  logic                o_soda, o_reject, o_busy;
  logic [CREDIT_W-1:0] o_change, o_credit;
  logic [COUNT_W-1:0]  o_sales;
  logic [1:0]          o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // model state
  int m_credit = 0, m_change = 0, m_sales = 0;
  bit m_pending = 0, m_soda = 0, m_reject = 0;

  vending_machine_param #(.PRICE_UNITS(PRICE_UNITS), .CREDIT_W(CREDIT_W), .COUNT_W(COUNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_nickle(i_nickle), .i_dime(i_dime),
    .i_quarter(i_quarter), .i_cancel(i_cancel), .i_ack(i_ack),
    .o_soda(o_soda), .o_change(o_change), .o_credit(o_credit), .o_reject(o_reject),
    .o_busy(o_busy), .o_sales(o_sales), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: outcome of one rising edge, stated in terms of coins, credit and outcomes
  task automatic model_step(input bit n, d, q, c, a, r);
    int ncoins, val;
    ncoins = int'(n) + int'(d) + int'(q);
    val = (ncoins != 1) ? 0 : (n ? 1 : (d ? 2 : 5));
    m_reject = 0;
    if (r) begin
      m_credit = 0; m_change = 0; m_sales = 0; m_pending = 0; m_soda = 0;
    end else if (m_pending) begin
      m_reject = (ncoins > 0);
      if (a) begin
        if (m_soda) m_sales = (m_sales + 1) % (1 << COUNT_W);
        m_pending = 0; m_soda = 0; m_change = 0;
      end
    end else begin
      m_reject = (ncoins > 1);
      if (c && (m_credit > 0 || ncoins == 1)) begin
        m_pending = 1; m_soda = 0; m_change = m_credit + val; m_credit = 0;
      end else if (ncoins == 1) begin
        if (m_credit + val >= PRICE_UNITS) begin
          m_pending = 1; m_soda = 1; m_change = m_credit + val - PRICE_UNITS; m_credit = 0;
        end else begin
          m_credit = m_credit + val;
        end
      end
    end
  endtask

  // driver: apply one vector for one clock and advance the model
  task automatic cyc(input bit n, d, q, c, a, r);
    i_nickle = n; i_dime = d; i_quarter = q; i_cancel = c; i_ack = a; i_rst = r;
    @(posedge i_clk);
    model_step(n, d, q, c, a, r);
    #1;
    i_nickle = 0; i_dime = 0; i_quarter = 0; i_cancel = 0; i_ack = 0; i_rst = 0;
  endtask

  task automatic idle();           cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic nick();           cyc(1, 0, 0, 0, 0, 0); endtask
  task automatic dime();           cyc(0, 1, 0, 0, 0, 0); endtask
  task automatic quar();           cyc(0, 0, 1, 0, 0, 0); endtask
  task automatic ack();            cyc(0, 0, 0, 0, 1, 0); endtask
  task automatic rst();            cyc(0, 0, 0, 0, 0, 1); endtask

  // scoreboard: the compare process, on every falling edge
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("soda",   int'(o_soda),   int'(m_soda));
      chk("change", int'(o_change), m_change);
      chk("credit", int'(o_credit), m_credit);
      chk("reject", int'(o_reject), int'(m_reject));
      chk("busy",   int'(o_busy),   int'(m_pending));
      chk("sales",  int'(o_sales),  m_sales);
    end
  end

  initial begin
    rst(); chk_en = 1'b1; rst();
    chk("rst_soda", int'(o_soda), 0);
    chk("rst_sales", int'(o_sales), 0);
    chk("rst_busy", int'(o_busy), 0);

    // quarter vends exactly, held without ack, then acknowledged
    quar();
    chk("q_soda", int'(o_soda), 1);
    chk("q_change", int'(o_change), 0);
    chk("q_busy", int'(o_busy), 1);
    idle(); idle(); idle();
    chk("hold_soda", int'(o_soda), 1);
    chk("hold_busy", int'(o_busy), 1);
    ack();
    chk("ack_busy", int'(o_busy), 0);
    chk("ack_sales", int'(o_sales), 1);

    // dime, dime, quarter
    dime(); chk("ddq_credit2", int'(o_credit), 2);
    dime(); chk("ddq_credit4", int'(o_credit), 4);
    quar();
    chk("ddq_change", int'(o_change), 4);
    chk("ddq_credit0", int'(o_credit), 0);
    ack(); chk("ddq_sales", int'(o_sales), 2);

    // nickel, dime, cancel -> refund 3, no sale
    nick(); dime(); cyc(0, 0, 0, 1, 0, 0);
    chk("ref_change", int'(o_change), 3);
    chk("ref_soda", int'(o_soda), 0);
    ack(); chk("ref_sales", int'(o_sales), 2);

    // two coins together in IDLE
    cyc(1, 0, 1, 0, 0, 0);
    chk("multi_reject", int'(o_reject), 1);
    chk("multi_credit", int'(o_credit), 0);
    idle(); chk("multi_reject_off", int'(o_reject), 0);

    // dime during VEND, then dime with ack
    dime(); dime(); dime();
    chk("ddd_change", int'(o_change), 1);
    dime();
    chk("vend_rej", int'(o_reject), 1);
    chk("vend_rej_change", int'(o_change), 1);
    cyc(0, 1, 0, 0, 1, 0);
    chk("vend_rej_ack", int'(o_reject), 1);
    chk("vend_ack_busy", int'(o_busy), 0);
    chk("vend_ack_sales", int'(o_sales), 3);
    idle();

    // cancel in IDLE: ignored alone, refunds a same-cycle coin
    cyc(0, 0, 0, 1, 0, 0);
    chk("idle_cancel_busy", int'(o_busy), 0);
    cyc(0, 1, 0, 1, 0, 0);
    chk("idle_cancel_coin", int'(o_change), 2);
    ack();

    // cancel beats reaching the price
    nick(); nick(); cyc(0, 0, 1, 1, 0, 0);
    chk("cancel_prio_change", int'(o_change), 7);
    chk("cancel_prio_soda", int'(o_soda), 0);
    ack();

    // cancel in COLLECT with refused coins
    nick(); cyc(0, 1, 1, 1, 0, 0); idle(); ack();

    // coins and cancel during REFUND
    nick(); cyc(0, 0, 0, 1, 0, 0); quar(); cyc(0, 0, 0, 1, 0, 0); ack();

    // ack while IDLE is ignored
    ack(); chk("idle_ack_sales", int'(o_sales), 3);

    // refused coins while collecting, then overshoot
    nick(); cyc(1, 1, 0, 0, 0, 0); ack(); quar();
    chk("over_change", int'(o_change), 1);
    ack();

    // exact price in nickels
    repeat (5) nick();
    chk("nick5_soda", int'(o_soda), 1);
    ack(); chk("nick5_sales", int'(o_sales), 5);

    // reset during VEND with 7 sales
    repeat (2) begin quar(); ack(); end
    quar();
    chk("pre_rst_sales", int'(o_sales), 7);
    rst();
    chk("vend_rst_soda", int'(o_soda), 0);
    chk("vend_rst_busy", int'(o_busy), 0);
    chk("vend_rst_sales", int'(o_sales), 0);

    // sales counter wraps
    repeat (256) begin quar(); ack(); end
    chk("wrap_sales", int'(o_sales), 0);
    idle();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
